// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM states, forwarding codes, memory timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LD_BUBBLE = 2'b01,
    ST_DM_WAIT   = 2'b10
  } hcu_state_t;

  // Operand source codes driven on fwdA/fwdB/fwdC.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Number of DM_WAIT cycles without dm_ack before the access is abandoned.
  localparam logic [3:0] DM_TIMEOUT_LIMIT = 4'd15;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// Picks the youngest in-flight producer of one source register (EX, then MEM, then WB).
// Latency: purely combinational.
// Backpressure: none; result is only meaningful while src_used=1, otherwise FWD_RF.
// Ports: src/src_used = register field and whether it is read;
//        {ex,mem,wb}_rd/_en = destination and writeback enable per stage; sel = FWD_* code.
module forward_select
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] src,
  input  logic       src_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_en,
  input  logic [4:0] mem_rd,
  input  logic       mem_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    // r0 is hardwired to zero, so a write to it must never be forwarded.
    if (src_used && (src != 5'd0)) begin
      if (ex_en && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_en && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_en && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: operand forwarding, load-use bubble, data-memory wait/timeout, delay-slot annul.
// Latency: all control outputs combinational from state + inputs; state, dm_timeout, stall_cnt registered.
// Backpressure: DM_WAIT freezes the whole pipe (pipe_hold) and front end until dm_ack or timeout.
// Ports: Clk/R clock and sync reset; ID_* decode fields; EX_/MEM_/WB_* stage info; dm_ack memory done;
//        PC_LE/nPC_LE/IF_ID_LE front-end enables; nop_sel bubble mux; IF_ID_flush delay-slot annul;
//        pipe_hold back-end freeze; dm_req memory request; fwdA/B/C operand sources;
//        dm_timeout sticky error; stall_cnt saturating stall-cycle count.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        R,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  ID_rd,
  input  logic        ID_use_rs2,
  input  logic        ID_store,
  input  logic        ID_B_instr,
  input  logic        ID_29_a,
  input  logic        ID_ba,
  input  logic        branch_taken,
  input  logic [4:0]  EX_rd,
  input  logic [4:0]  MEM_rd,
  input  logic [4:0]  WB_rd,
  input  logic        EX_RF_enable,
  input  logic        MEM_RF_enable,
  input  logic        WB_RF_enable,
  input  logic        EX_load_instr,
  input  logic        MEM_load_instr,
  input  logic        MEM_Read_Write,
  input  logic        dm_ack,
  output logic        PC_LE,
  output logic        nPC_LE,
  output logic        IF_ID_LE,
  output logic        nop_sel,
  output logic        IF_ID_flush,
  output logic        pipe_hold,
  output logic        dm_req,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic [1:0]  fwdC,
  output logic        dm_timeout,
  output logic [15:0] stall_cnt
);

  hcu_state_t state;
  hcu_state_t state_nxt;
  logic [3:0] wait_cnt;
  logic       load_use;
  logic       mem_miss;
  logic       wait_expired;
  logic       front_le;
  logic       annul_cond;

  // Loads and stores share the same request/ack handshake; the direction only
  // matters to the memory itself.
  logic mem_rw_unused;
  assign mem_rw_unused = MEM_Read_Write;

  // ---------------------------------------------------------------- forwarding
  // Forcing "not used" during reset drives every select to FWD_RF.
  forward_select u_fwd_rs1 (
    .src      (ID_rs1),
    .src_used (!R),
    .ex_rd    (EX_rd),
    .ex_en    (EX_RF_enable),
    .mem_rd   (MEM_rd),
    .mem_en   (MEM_RF_enable),
    .wb_rd    (WB_rd),
    .wb_en    (WB_RF_enable),
    .sel      (fwdA)
  );

  forward_select u_fwd_rs2 (
    .src      (ID_rs2),
    .src_used (ID_use_rs2 && !R),
    .ex_rd    (EX_rd),
    .ex_en    (EX_RF_enable),
    .mem_rd   (MEM_rd),
    .mem_en   (MEM_RF_enable),
    .wb_rd    (WB_rd),
    .wb_en    (WB_RF_enable),
    .sel      (fwdB)
  );

  forward_select u_fwd_rd (
    .src      (ID_rd),
    .src_used (ID_store && !R),
    .ex_rd    (EX_rd),
    .ex_en    (EX_RF_enable),
    .mem_rd   (MEM_rd),
    .mem_en   (MEM_RF_enable),
    .wb_rd    (WB_rd),
    .wb_en    (WB_RF_enable),
    .sel      (fwdC)
  );

  // ---------------------------------------------------------------- hazards
  // A load in EX cannot forward in time; any consumer in ID needs one bubble.
  assign load_use = EX_load_instr && EX_RF_enable && (EX_rd != 5'd0) &&
                    ((EX_rd == ID_rs1) ||
                     (ID_use_rs2 && (EX_rd == ID_rs2)) ||
                     (ID_store   && (EX_rd == ID_rd)));

  assign mem_miss = MEM_load_instr && !dm_ack;

  // wait_cnt counts completed DM_WAIT cycles, so the last allowed cycle sees LIMIT-1.
  assign wait_expired = (state == ST_DM_WAIT) && !dm_ack &&
                        (wait_cnt == (DM_TIMEOUT_LIMIT - 4'd1));

  // Annulled delay slot: a=1 with the branch not taken, or branch-always.
  assign annul_cond = ID_B_instr && ID_29_a && (!branch_taken || ID_ba);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    front_le  = 1'b1;
    nop_sel   = 1'b0;
    pipe_hold = 1'b0;
    dm_req    = 1'b0;
    case (state)
      ST_RUN: begin
        dm_req = MEM_load_instr;
        // An outstanding memory access wins; the load-use check is redone
        // once the pipe is released.
        if (mem_miss) begin
          state_nxt = ST_DM_WAIT;
        end else if (load_use) begin
          front_le  = 1'b0;
          nop_sel   = 1'b1;
          state_nxt = ST_LD_BUBBLE;
        end
      end
      ST_LD_BUBBLE: begin
        // The producing load has moved to MEM this cycle, so it may need memory.
        // The hazard it caused is already covered by the inserted bubble.
        dm_req    = MEM_load_instr;
        state_nxt = mem_miss ? ST_DM_WAIT : ST_RUN;
      end
      ST_DM_WAIT: begin
        dm_req    = 1'b1;
        pipe_hold = 1'b1;
        front_le  = 1'b0;
        if (dm_ack || wait_expired) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (R) begin
      state_nxt = ST_RUN;
      front_le  = 1'b1;
      nop_sel   = 1'b0;
      pipe_hold = 1'b0;
      dm_req    = 1'b0;
    end
  end

  assign PC_LE    = front_le;
  assign nPC_LE   = front_le;
  assign IF_ID_LE = front_le;
  // Held back while IF/ID is frozen; reappears when the stall releases.
  assign IF_ID_flush = annul_cond && front_le && !R;

  always_ff @(posedge Clk) begin
    if (R) begin
      state      <= ST_RUN;
      wait_cnt   <= 4'd0;
      dm_timeout <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      // Held at zero outside DM_WAIT, so it always starts clean on entry.
      if (state == ST_DM_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
      if (wait_expired) begin
        dm_timeout <= 1'b1;
      end
      if (!front_le && (stall_cnt != STALL_CNT_MAX)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
